// File: rtl/requant_pack_if.sv
// ============================================================================
//  Module      : requant_pack_if
//  Description : Element-in / packed-word-out bundle for requant_pack.
//                The element side has no backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface requant_pack_if;
    logic               data_valid_i;
    logic signed [31:0] data_i;
    logic        [15:0] scale_i;
    logic        [4:0]  shift_i;
    logic               flush_i;
    logic               data_valid_o;
    logic        [31:0] data_o;
    logic        [3:0]  byte_en_o;

    // Producer of elements and consumer of packed words
    modport master (
        output data_valid_i, data_i, scale_i, shift_i, flush_i,
        input  data_valid_o, data_o, byte_en_o
    );

    // The requant/pack block itself
    modport slave (
        input  data_valid_i, data_i, scale_i, shift_i, flush_i,
        output data_valid_o, data_o, byte_en_o
    );
endinterface

`default_nettype wire

// File: rtl/requant_pack.sv
// ============================================================================
//  Module      : requant_pack
//  Description : Rescales signed 32-bit elements with (x * scale) rounding
//                right-shift, saturates the result to int8, and packs four
//                bytes little-endian per 32-bit word. A flush emits any
//                partial word together with a byte-enable mask.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module requant_pack (
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    requant_pack_if.slave bus
);

    // ------------------------------------------------------------------
    // Stage 1 : multiply
    // ------------------------------------------------------------------
    logic signed [48:0] prod_full;
    logic signed [47:0] s1_prod;
    logic        [4:0]  s1_shift;
    logic               s1_valid;
    logic               s1_flush;

    // The scale is unsigned, so it gets a zero sign bit before the signed multiply
    assign prod_full = $signed(bus.data_i) * $signed({1'b0, bus.scale_i});

    // Register the product along with its shift and the flush marker
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_prod  <= '0;
            s1_shift <= '0;
            s1_valid <= 1'b0;
            s1_flush <= 1'b0;
        end else begin
            s1_prod  <= prod_full[47:0];
            s1_shift <= bus.shift_i;
            s1_valid <= bus.data_valid_i;
            s1_flush <= bus.flush_i;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 : round half-up and saturate to int8
    // ------------------------------------------------------------------
    logic signed [48:0] prod_ext;
    logic signed [48:0] rnd_bias;
    logic signed [48:0] rnd_sum;
    logic signed [48:0] rounded;
    logic        [7:0]  sat_byte;
    logic        [7:0]  s2_byte;
    logic               s2_valid;
    logic               s2_flush;

    // Widen by one bit so adding the half-LSB bias cannot overflow
    always_comb begin
        prod_ext = {s1_prod[47], s1_prod};
        rnd_bias = '0;
        if (s1_shift != 5'd0) begin
            rnd_bias = 49'sd1 <<< (s1_shift - 5'd1);
        end
        rnd_sum = prod_ext + rnd_bias;
        rounded = rnd_sum >>> s1_shift;
        if (rounded > 49'sd127) begin
            sat_byte = 8'h7F;
        end else if (rounded < -49'sd128) begin
            sat_byte = 8'h80;
        end else begin
            sat_byte = rounded[7:0];
        end
    end

    // Register the saturated byte along with its valid and flush marker
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_byte  <= '0;
            s2_valid <= 1'b0;
            s2_flush <= 1'b0;
        end else begin
            s2_byte  <= sat_byte;
            s2_valid <= s1_valid;
            s2_flush <= s1_flush;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3 : pack into lanes, emit full or flushed partial words
    // ------------------------------------------------------------------
    logic [31:0] pack_q;
    logic [1:0]  lane_q;
    logic [31:0] pack_nx;
    logic [1:0]  lane_nx;
    logic        emit;
    logic [31:0] emit_data;
    logic [3:0]  emit_be;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_be;

    // The carried byte is placed first; the flush then sees the updated
    // lane count, so a word that just completed produces no empty partial.
    always_comb begin
        pack_nx   = pack_q;
        lane_nx   = lane_q;
        emit      = 1'b0;
        emit_data = out_data;
        emit_be   = out_be;
        if (s2_valid) begin
            pack_nx[{lane_q, 3'b000} +: 8] = s2_byte;
            if (lane_q == 2'd3) begin
                emit      = 1'b1;
                emit_data = pack_nx;
                emit_be   = 4'hF;
                pack_nx   = '0;
                lane_nx   = 2'd0;
            end else begin
                lane_nx = lane_q + 2'd1;
            end
        end
        if (s2_flush && (lane_nx != 2'd0)) begin
            emit      = 1'b1;
            emit_data = pack_nx;
            emit_be   = (4'b0001 << lane_nx) - 4'b0001;
            pack_nx   = '0;
            lane_nx   = 2'd0;
        end
    end

    // Pack state plus output registers; data and byte enables hold between pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pack_q    <= '0;
            lane_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_be    <= '0;
        end else begin
            pack_q    <= pack_nx;
            lane_q    <= lane_nx;
            out_valid <= emit;
            if (emit) begin
                out_data <= emit_data;
                out_be   <= emit_be;
            end
        end
    end

    assign bus.data_valid_o = out_valid;
    assign bus.data_o       = out_data;
    assign bus.byte_en_o    = out_be;

endmodule

`default_nettype wire

// File: doc/requant_pack.md
# requant_pack

Post-activation output stage of the accumulator datapath. Consumes the signed 32-bit valid-only stream produced by the activation stage and rescales each element: multiply by an unsigned scale, rounding right-shift, saturate to int8. Packs four int8 results little-endian into a 32-bit word for the output buffer writer. A flush request emits any partial word with a byte-enable mask.

## Interface
Parameters:
- none; all widths are fixed.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- data_valid_i  in  1  element valid; no backpressure, accepted every cycle it is high
- data_i  in  32  signed accumulator/activation value
- scale_i  in  16  unsigned multiplier, sampled with each valid element
- shift_i  in  5  right-shift amount 0..31, sampled with each valid element
- flush_i  in  1  single-cycle request to emit the pending partial word; may coincide with data_valid_i
- data_valid_o  out  1  one-cycle pulse per emitted word
- data_o  out  32  packed word; byte k (bits 8k+7:8k) is the k-th element of the word
- byte_en_o  out  4  lane k valid; 4'hF for full words

## Operation
- Stage 1: prod = data_i * $signed({1'b0, scale_i}), 48-bit signed. Register prod, shift, valid and flush marker.
- Stage 2, rounding: if shift = 0, r = prod. Otherwise r = (prod + 2^(shift-1)) >>> shift, computed at 49 bits so no overflow. This is round-half-up, so ties round toward +inf.
- Stage 2, saturation: r > 127 → 8'h7F; r < -128 → 8'h80; else r[7:0]. Register the byte, valid and flush marker.
- Stage 3, pack: a 2-bit lane counter starts at 0.
  - On byte valid: write the byte into lane[counter] of the pack register and increment the counter (wraps 3→0).
  - When the written lane is 3: load data_o with the completed word, set byte_en_o = 4'hF, pulse data_valid_o, and clear the pack register.
- Flush marker at stage 3:
  - It is processed after any byte carried with it.
  - If the counter is nonzero after that byte: emit the partial word. Unused lanes are 0; byte_en_o = (1<<counter)-1. Then reset the counter and clear the pack register.
  - If the counter is 0 (nothing pending, or the word just completed): no extra output.
- Flush is carried through the pipeline with the data. A flush coincident with an element applies after that element.
- data_o and byte_en_o hold their value between pulses.
- Scale and shift travel with each element, so changing them between elements is legal.

## Timing
- Reset values: data_valid_o = 0, data_o = 0, byte_en_o = 0. Lane counter, pack register and all stage valids/flush markers are 0. In-flight elements and the partial word are discarded.
- Latency: element in cycle 0 → its byte lands in the pack register at the end of cycle 2 → completed word visible with data_valid_o in cycle 3.
- Throughput: one element per cycle, one full word per 4 cycles at most.
- A flush in cycle t with no coincident data → partial word visible in cycle t+3.
- Reset takes priority over all activity in the same cycle. After reset deasserts, the first valid element always goes to lane 0.

## Test plan
- scale=1, shift=0, inputs 1,2,3,4 on consecutive cycles → data_o=32'h04030201, byte_en_o=4'hF, data_valid_o high for exactly one cycle, 3 cycles after input 4.
- Saturation: scale=1, shift=0, inputs 300, -300, 127, -128 → data_o=32'h807F807F.
- Rounding: scale=3, shift=2, inputs 5, -5, 2, -2 → bytes 04, FC, 02, FF → data_o=32'hFF02FC04.
- Flush: inputs 1,2 (scale=1, shift=0), then flush_i alone → data_o=32'h00000201, byte_en_o=4'h3. A second flush with nothing pending → no data_valid_o.
- Flush coincident with the 4th of 8 back-to-back inputs (values 1..8) → exactly two pulses: 32'h04030201 then 32'h08070605, 4 cycles apart, no empty partial word.
- Reset mid-word: 3 inputs, assert rst_i one cycle, then inputs 9,10,11,12 → single word 32'h0C0B0A09, no residue from before reset.
